// File: rtl/fifo_sync.sv
// Single-clock power-of-two FIFO with an exact fill count, programmable almost
// thresholds, sticky overflow/underflow, and registered or fall-through reads.
module fifo_sync #(
    parameter int WD     = 8,
    parameter int WA     = 3,
    parameter int AF_LVL = (1 << WA) - 2,
    parameter int AE_LVL = 2,
    parameter int FWFT   = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [WD-1:0] wdata,
    input  logic          rd_en,
    input  logic          clr_err,
    output logic [WD-1:0] rdata,
    output logic          rdata_valid,
    output logic          full,
    output logic          almost_full,
    output logic          empty,
    output logic          almost_empty,
    output logic [WA:0]   count,
    output logic          overflow,
    output logic          underflow
);

    localparam int DEPTH = 1 << WA;
    localparam logic [WA:0] DEPTH_C = (WA + 1)'(DEPTH);
    localparam logic [WA:0] AF_C    = (WA + 1)'(AF_LVL);
    localparam logic [WA:0] AE_C    = (WA + 1)'(AE_LVL);

    logic [WD-1:0] mem [DEPTH];
    logic [WA-1:0] wptr;
    logic [WA-1:0] rptr;
    logic [WA:0]   cnt;
    logic          wacc;
    logic          racc;

    // Handshake: wr_en is a write valid whose ready is !full, rd_en is a read
    // request whose ready is !empty; an access is taken only at an edge where
    // both are high, and a refused access only touches the sticky error flags.
    assign wacc = wr_en & ~full;
    assign racc = rd_en & ~empty;

    assign full         = (cnt == DEPTH_C);
    assign empty        = (cnt == '0);
    assign almost_full  = (cnt >= AF_C);
    assign almost_empty = (cnt <= AE_C);
    assign count        = cnt;

    // Storage is not reset; the rst_n gate keeps a write from landing during reset.
    always_ff @(posedge clk) begin
        if (wacc && rst_n) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wacc) begin
                wptr <= wptr + 1'b1;
            end
            if (racc) begin
                rptr <= rptr + 1'b1;
            end
            case ({wacc, racc})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Set has priority over clear so an error in the clearing cycle is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown directly; zero while empty so reset shows zero.
            assign rdata       = empty ? '0 : mem[rptr];
            assign rdata_valid = ~empty;
        end else begin : g_reg
            logic [WD-1:0] rdata_q;
            logic          valid_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= racc;
                    if (racc) begin
                        rdata_q <= mem[rptr];
                    end
                end
            end

            assign rdata       = rdata_q;
            assign rdata_valid = valid_q;
        end
    endgenerate

endmodule
